ic_cpu_bus_initiator: RTL and testbench

IC_CPU_BUS_INITIATOR -- requirements
Module: ic_cpu_bus_initiator

---
 rtl/ic_bus_pkg.sv | 23 ++
 rtl/ic_bus_rsp_fifo.sv | 76 +++++++
 rtl/ic_cpu_bus_initiator.sv | 143 ++++++++++++++
 tb/tb_ic_cpu_bus_initiator.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ic_bus_pkg.sv
// ============================================================================
// Package  : ic_bus_pkg
// Brief    : Shared widths, defaults and response-entry layout for the CPU bus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ic_bus_pkg;

  localparam int c_max_outstanding_def = 2;
  localparam int c_addr_w              = 32;
  localparam int c_data_w              = 32;
  localparam int c_strb_w              = 4;
  localparam int c_rsp_w               = 1 + c_data_w;

  typedef struct packed {
    logic                error;
    logic [c_data_w-1:0] rdata;
  } rsp_entry_t;

endpackage

`default_nettype wire

// File: rtl/ic_bus_rsp_fifo.sv
// ============================================================================
// Module   : ic_bus_rsp_fifo
// Brief    : Flop-based synchronous FIFO; push and pop may coincide even when full.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ic_bus_rsp_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 33
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_data,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_data,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cnt_w = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic               w_full;
  logic               w_do_push;
  logic               w_do_pop;

  function automatic logic [c_ptr_w-1:0] next_ptr(input logic [c_ptr_w-1:0] ptr);
    if (ptr == c_ptr_w'(DEPTH - 1)) begin
      return '0;
    end
    return ptr + 1'b1;
  endfunction

  assign o_empty   = (r_count == '0);
  assign w_full    = (r_count == c_cnt_w'(DEPTH));
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  // When full, the head slot is read this cycle and overwritten at the edge.
  assign w_do_push = i_push & (~w_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= next_ptr(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/ic_cpu_bus_initiator.sv
// ============================================================================
// Module   : ic_cpu_bus_initiator
// Brief    : Credit-limited CPU command to req/gnt + recv/ack bus initiator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ic_cpu_bus_initiator
  import ic_bus_pkg::*;
#(
  parameter int MAX_OUTSTANDING = c_max_outstanding_def  // legal 1..4
) (
  input  logic                g_clk,
  input  logic                g_reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_wen,
  input  logic [c_strb_w-1:0] cmd_strb,
  input  logic [c_addr_w-1:0] cmd_addr,
  input  logic [c_data_w-1:0] cmd_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_error,
  output logic [c_data_w-1:0] rsp_rdata,
  output logic                mem_req,
  input  logic                mem_gnt,
  output logic                mem_wen,
  output logic [c_strb_w-1:0] mem_strb,
  output logic [c_addr_w-1:0] mem_addr,
  output logic [c_data_w-1:0] mem_wdata,
  input  logic                mem_recv,
  output logic                mem_ack,
  input  logic                mem_error,
  input  logic [c_data_w-1:0] mem_rdata,
  output logic                busy
);

  localparam int c_cnt_w = $clog2(MAX_OUTSTANDING + 1);

  logic                r_run;
  logic                r_req;
  logic                r_wen;
  logic [c_strb_w-1:0] r_strb;
  logic [c_addr_w-1:0] r_addr;
  logic [c_data_w-1:0] r_wdata;
  logic [c_cnt_w-1:0]  r_inflight;

  logic                w_gnt;
  logic                w_recv;
  logic                w_pop;
  logic                w_accept;
  logic                w_fifo_empty;
  logic [c_cnt_w-1:0]  w_fifo_count;
  logic [3:0]          w_used;
  logic [3:0]          w_used_after_pop;
  rsp_entry_t          w_push_entry;
  rsp_entry_t          w_head;

  assign w_gnt            = r_req & mem_gnt;
  assign mem_ack          = (r_inflight != '0);
  assign w_recv           = mem_recv & mem_ack;
  assign rsp_valid        = ~w_fifo_empty;
  assign w_pop            = rsp_valid & rsp_ready;

  // Every credit is a slot somewhere: request register, on the bus, or buffered.
  assign w_used           = 4'(r_req) + 4'(r_inflight) + 4'(w_fifo_count);
  assign w_used_after_pop = w_used - 4'(w_pop);
  assign cmd_ready        = r_run & (~r_req | mem_gnt)
                          & (w_used_after_pop < 4'(MAX_OUTSTANDING));
  assign w_accept         = cmd_valid & cmd_ready;

  assign mem_req   = r_req;
  assign mem_wen   = r_wen;
  assign mem_strb  = r_strb;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign busy      = r_req | mem_ack | rsp_valid;

  assign w_push_entry.error = mem_error;
  assign w_push_entry.rdata = mem_rdata;
  assign rsp_error          = w_head.error;
  assign rsp_rdata          = w_head.rdata;

  // Holds off acceptance until the first edge after reset release.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      r_req   <= 1'b0;
      r_wen   <= 1'b0;
      r_strb  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_req   <= 1'b1;
      r_wen   <= cmd_wen;
      r_strb  <= cmd_strb;
      r_addr  <= cmd_addr;
      r_wdata <= cmd_wdata;
    end else if (w_gnt) begin
      r_req   <= 1'b0;
    end
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      r_inflight <= '0;
    end else begin
      case ({w_gnt, w_recv})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  ic_bus_rsp_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (c_rsp_w)
  ) u_rsp_fifo (
    .clk     (g_clk),
    .rst     (g_reset),
    .i_push  (w_recv),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  a_spurious_recv : assert property (@(posedge g_clk) disable iff (g_reset)
                                     !(mem_recv && !mem_ack))
    else $warning("ic_cpu_bus_initiator: mem_recv with nothing in flight ignored");

endmodule

`default_nettype wire

// File: tb/tb_ic_cpu_bus_initiator.sv
// ============================================================================
// Module   : tb_ic_cpu_bus_initiator
// Brief    : Directed bench with a response scoreboard for ic_cpu_bus_initiator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ic_cpu_bus_initiator;

  logic        g_clk;
  logic        g_reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wen;
  logic [3:0]  cmd_strb;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_error;
  logic [31:0] rsp_rdata;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_wen;
  logic [3:0]  mem_strb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_recv;
  logic        mem_ack;
  logic        mem_error;
  logic [31:0] mem_rdata;
  logic        busy;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_gnt    = 0;
  int          gnt_snap;
  logic [33:0] exp_q [$];   // {is_write, error, rdata}

  ic_cpu_bus_initiator #(.MAX_OUTSTANDING(2)) dut (
    .g_clk     (g_clk),
    .g_reset   (g_reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_wen   (cmd_wen),
    .cmd_strb  (cmd_strb),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_error (rsp_error),
    .rsp_rdata (rsp_rdata),
    .mem_req   (mem_req),
    .mem_gnt   (mem_gnt),
    .mem_wen   (mem_wen),
    .mem_strb  (mem_strb),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_recv  (mem_recv),
    .mem_ack   (mem_ack),
    .mem_error (mem_error),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  always @(posedge g_clk) begin
    if (mem_req && mem_gnt) n_gnt <= n_gnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic drive_cmd(input logic wen, input logic [3:0] strb,
                           input logic [31:0] addr, input logic [31:0] wdata);
    cmd_valid = 1'b1;
    cmd_wen   = wen;
    cmd_strb  = strb;
    cmd_addr  = addr;
    cmd_wdata = wdata;
  endtask

  task automatic drive_recv(input logic is_wr, input logic err, input logic [31:0] data);
    mem_recv  = 1'b1;
    mem_error = err;
    mem_rdata = data;
    exp_q.push_back({is_wr, err, data});
  endtask

  task automatic pop_check(input string tag);
    logic [33:0] e;
    chk({tag, "_valid"}, 64'(rsp_valid), 64'd1);
    n_checks++;
    assert (exp_q.size() != 0) else begin
      n_fail++;
      $error("FAIL %s_sb: observed a response, expected none queued", tag);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (e[33]) chk({tag, "_err"}, 64'(rsp_error), 64'(e[32]));
      else       chk({tag, "_rsp"}, 64'({rsp_error, rsp_rdata}), 64'(e[32:0]));
    end
  endtask

  initial begin
    g_reset = 1'b1; cmd_valid = 1'b0; cmd_wen = 1'b0; cmd_strb = '0;
    cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0; mem_gnt = 1'b0;
    mem_recv = 1'b0; mem_error = 1'b0; mem_rdata = '0;

    // ---- reset state ----
    tick(); tick();
    chk("rst_mem_req",   64'(mem_req),   64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_mem_ack",   64'(mem_ack),   64'd0);
    chk("rst_fields",    64'({mem_wen, mem_strb, mem_addr}), 64'd0);
    g_reset = 1'b0;
    #1 chk("rel_cmd_ready_early", 64'(cmd_ready), 64'd0);
    tick();
    chk("rel_cmd_ready", 64'(cmd_ready), 64'd1);

    // ---- single read, zero-wait ----
    drive_cmd(1'b0, 4'hF, 32'h1000_0004, 32'h0);
    #1 chk("rd_cmd_ready", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0; mem_gnt = 1'b1;
    #1 chk("rd_mem_req", 64'(mem_req), 64'd1);
    chk("rd_fields", 64'({mem_wen, mem_addr}), 64'({1'b0, 32'h1000_0004}));
    tick();
    mem_gnt = 1'b0; drive_recv(1'b0, 1'b0, 32'hDEAD_BEEF);
    #1 chk("rd_req_drop", 64'(mem_req), 64'd0);
    chk("rd_ack", 64'(mem_ack), 64'd1);
    chk("rd_no_rsp_yet", 64'(rsp_valid), 64'd0);
    tick();
    mem_recv = 1'b0; rsp_ready = 1'b1;
    #1 pop_check("rd");
    tick();
    rsp_ready = 1'b0;
    #1 chk("rd_busy_after", 64'(busy), 64'd0);

    // ---- grant stall on a write ----
    gnt_snap = n_gnt;
    drive_cmd(1'b1, 4'b0011, 32'h2000_0010, 32'h1234_5678);
    tick();
    cmd_valid = 1'b0; cmd_wen = 1'b0; cmd_strb = '0; cmd_addr = '0; cmd_wdata = '0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("st_req",   64'(mem_req), 64'd1);
      chk("st_hdr",   64'({mem_wen, mem_strb, mem_addr}), 64'({1'b1, 4'b0011, 32'h2000_0010}));
      chk("st_wdata", 64'(mem_wdata), 64'h1234_5678);
      chk("st_ready", 64'(cmd_ready), 64'd0);
      tick();
    end
    mem_gnt = 1'b1;
    #1 chk("st_req_at_gnt", 64'(mem_req), 64'd1);
    tick();
    mem_gnt = 1'b0; drive_recv(1'b1, 1'b0, 32'h0);
    #1 chk("st_req_drop", 64'(mem_req), 64'd0);
    chk("st_one_grant", 64'(n_gnt - gnt_snap), 64'd1);
    tick();
    mem_recv = 1'b0; rsp_ready = 1'b1;
    #1 pop_check("wr");
    tick();
    rsp_ready = 1'b0;

    // ---- back-pressure with two credits ----
    drive_cmd(1'b0, 4'hF, 32'h3000_0000, 32'h0);
    #1 chk("bp_rdy1", 64'(cmd_ready), 64'd1);
    tick();
    mem_gnt = 1'b1; cmd_addr = 32'h3000_0004;
    #1 chk("bp_rdy2", 64'(cmd_ready), 64'd1);
    tick();
    cmd_addr = 32'h3000_0008; drive_recv(1'b0, 1'b0, 32'hA000_0001);
    #1 chk("bp_rdy_drop", 64'(cmd_ready), 64'd0);
    tick();
    mem_gnt = 1'b0; drive_recv(1'b0, 1'b0, 32'hA000_0002);
    #1 chk("bp_rdy_hold1", 64'(cmd_ready), 64'd0);
    tick();
    mem_recv = 1'b0;
    #1 chk("bp_rdy_hold2", 64'(cmd_ready), 64'd0);
    tick();
    #1 chk("bp_rdy_hold3", 64'(cmd_ready), 64'd0);
    rsp_ready = 1'b1;
    #1 chk("bp_rdy_on_pop", 64'(cmd_ready), 64'd1);
    pop_check("bp1");
    tick();
    rsp_ready = 1'b0; cmd_valid = 1'b0; mem_gnt = 1'b1;
    #1 chk("bp_third_req", 64'({mem_req, mem_addr}), 64'({1'b1, 32'h3000_0008}));
    tick();
    mem_gnt = 1'b0; drive_recv(1'b0, 1'b0, 32'hA000_0003);
    tick();
    mem_recv = 1'b0; rsp_ready = 1'b1;
    #1 pop_check("bp2");
    tick();
    pop_check("bp3");
    tick();
    rsp_ready = 1'b0;
    #1 chk("bp_busy_after", 64'(busy), 64'd0);

    // ---- grant of B and recv of A in the same cycle ----
    drive_cmd(1'b0, 4'hF, 32'h4000_0000, 32'h0);
    tick();
    mem_gnt = 1'b1; cmd_addr = 32'h4000_0040;
    #1 chk("sim_rdy_b", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0; drive_recv(1'b0, 1'b0, 32'h0000_00AA);
    #1 chk("sim_ack", 64'(mem_ack), 64'd1);
    chk("sim_addr_b", 64'(mem_addr), 64'h4000_0040);
    tick();
    mem_gnt = 1'b0; mem_recv = 1'b0;
    #1 chk("sim_inflight_kept", 64'(mem_ack), 64'd1);
    chk("sim_req_drop", 64'(mem_req), 64'd0);
    drive_recv(1'b0, 1'b0, 32'h0000_00BB);
    tick();
    mem_recv = 1'b0;
    #1 chk("sim_ack_done", 64'(mem_ack), 64'd0);
    rsp_ready = 1'b1;
    #1 pop_check("simA");
    tick();
    pop_check("simB");
    tick();
    rsp_ready = 1'b0;

    // ---- error response, then spurious recv ----
    drive_cmd(1'b0, 4'hF, 32'h5000_0000, 32'h0);
    tick();
    cmd_valid = 1'b0; mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; drive_recv(1'b0, 1'b1, 32'hBAD0_0BAD);
    tick();
    mem_recv = 1'b0;
    #1 chk("err_flag", 64'(rsp_error), 64'd1);
    rsp_ready = 1'b1;
    #1 pop_check("err");
    tick();
    rsp_ready = 1'b0;
    mem_recv = 1'b1; mem_error = 1'b0; mem_rdata = 32'h7777_7777;
    #1 chk("spur_ack", 64'(mem_ack), 64'd0);
    tick();
    mem_recv = 1'b0;
    #1 chk("spur_no_rsp", 64'(rsp_valid), 64'd0);
    chk("spur_busy", 64'(busy), 64'd0);

    // ---- reset with one in flight and one buffered ----
    drive_cmd(1'b0, 4'hF, 32'h6000_0000, 32'hFFFF_FFFF);
    tick();
    mem_gnt = 1'b1; cmd_addr = 32'h6000_0004;
    tick();
    cmd_valid = 1'b0; drive_recv(1'b0, 1'b0, 32'h1111_2222);
    tick();
    mem_gnt = 1'b0; mem_recv = 1'b0;
    #1 chk("mr_pre_rsp", 64'(rsp_valid), 64'd1);
    chk("mr_pre_ack", 64'(mem_ack), 64'd1);
    g_reset = 1'b1;
    #1;
    chk("mr_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mr_ack",       64'(mem_ack),   64'd0);
    chk("mr_busy",      64'(busy),      64'd0);
    chk("mr_ready",     64'(cmd_ready), 64'd0);
    chk("mr_req",       64'(mem_req),   64'd0);
    chk("mr_fields",    64'({mem_wen, mem_strb, mem_addr}), 64'd0);
    chk("mr_wdata",     64'(mem_wdata), 64'd0);
    exp_q.delete();
    tick(); tick();
    g_reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mr_post_rsp", 64'(rsp_valid), 64'd0);
      chk("mr_post_ack", 64'(mem_ack),   64'd0);
    end
    chk("mr_post_ready", 64'(cmd_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
